// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared state encoding, partial-sum bound and saturating adder for the perceptron layers
package perceptron_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int PARTIAL_MAX = 84;

   // Returns {sat, sum}: sum clamps to 2^w-1 when the true sum does not fit in w bits (w <= 32).
   function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? {1'b1, m[31:0]} : {1'b0, s[31:0]};
   endfunction

endpackage

// File: rtl/perceptron_accumulator.sv
// perceptron_accumulator: sums a neuron's partial-sum beats and presents the thresholded result over valid/ready
module perceptron_accumulator
   import perceptron_pkg::*;
#(
   parameter int SUM_W     = 7,
   parameter int ACC_W     = 12,
   parameter int MAX_BEATS = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             in_first,
   input  logic             in_last,
   input  logic [ACC_W-1:0] thresh,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_fire,
   output logic             out_sat,
   output logic             out_overrun
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] thresh_q;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             sat;
   logic             overrun;
   logic             accept;
   logic [32:0]      add;

   assign in_ready    = state != DONE;
   assign accept      = in_valid & in_ready;
   assign add         = sat_add(32'(acc), 32'(in_sum), ACC_W);
   assign cnt_inc     = beat_cnt + CNT_W'(1);
   assign out_valid   = state == DONE;
   assign out_sum     = out_valid ? acc : '0;
   assign out_fire    = out_valid & (acc >= thresh_q);
   assign out_sat     = out_valid & sat;
   assign out_overrun = out_valid & overrun;

   // A first beat always (re)starts a neuron; later beats accumulate until last, the beat limit, or the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         thresh_q <= '0;
         beat_cnt <= '0;
         sat      <= 1'b0;
         overrun  <= 1'b0;
      end else if (accept && in_first) begin
         acc      <= ACC_W'(in_sum);
         thresh_q <= thresh;
         beat_cnt <= CNT_W'(1);
         sat      <= 1'b0;
         overrun  <= (MAX_BEATS == 1) && !in_last;
         state    <= (in_last || MAX_BEATS == 1) ? DONE : ACC;
      end else if (accept && state == ACC) begin
         acc      <= ACC_W'(add);
         sat      <= sat | add[32];
         beat_cnt <= cnt_inc;
         if (in_last) begin
            state <= DONE;
         end else if (cnt_inc == CNT_W'(MAX_BEATS)) begin
            state   <= DONE;
            overrun <= 1'b1;
         end
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_perceptron_accumulator.sv
// tb_perceptron_accumulator: directed scenarios on a narrow instance (ACC_W=8, MAX_BEATS=4)
module tb_perceptron_accumulator;

   localparam int SW = 7;
   localparam int AW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [SW-1:0] in_sum = '0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic [AW-1:0] thresh = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_sum;
   logic          out_fire;
   logic          out_sat;
   logic          out_overrun;

   int errors = 0;
   int checks = 0;

   perceptron_accumulator #(.SUM_W(SW), .ACC_W(AW), .MAX_BEATS(MB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .in_first(in_first), .in_last(in_last), .thresh(thresh), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_fire(out_fire), .out_sat(out_sat),
      .out_overrun(out_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one beat for exactly one edge; returns 1 time unit after that edge.
   task automatic beat(input logic [SW-1:0] s, input logic f, input logic l, input logic [AW-1:0] th);
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = s;
      in_first = f;
      in_last  = l;
      thresh   = th;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      pulse_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
         errors++;
         $display("FAIL reset: valid=%b ready=%b sum=%0d, need valid=0 ready=1 sum=0", out_valid, in_ready, out_sum);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_three_beats();
      beat(84, 1, 0, 150);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL three_beats_early: valid=%b need 0", out_valid);
      end
      beat(84, 0, 0, 0);
      beat(10, 0, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd178 || out_fire !== 1'b1 || out_sat !== 1'b0 || out_overrun !== 1'b0) begin
         errors++;
         $display("FAIL three_beats: valid=%b sum=%0d fire=%b sat=%b ov=%b, need 1 178 1 0 0",
                  out_valid, out_sum, out_fire, out_sat, out_overrun);
      end
      take_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_clear: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      beat(5, 1, 1, 6);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_fire !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_beat: valid=%b sum=%0d fire=%b ready=%b, need 1 5 0 0", out_valid, out_sum, out_fire, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = 9;
      in_first = 1'b1;
      in_last  = 1'b1;
      thresh   = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_fire !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: valid=%b sum=%0d fire=%b ready=%b, need 1 5 0 0", i, out_valid, out_sum, out_fire, in_ready);
         end
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      take_result();
   endtask

   task automatic test_saturation();
      beat(84, 1, 0, 0);
      beat(84, 0, 0, 0);
      beat(84, 0, 0, 0);
      beat(84, 0, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd255 || out_sat !== 1'b1 || out_overrun !== 1'b0) begin
         errors++;
         $display("FAIL saturate: valid=%b sum=%0d sat=%b ov=%b, need 1 255 1 0", out_valid, out_sum, out_sat, out_overrun);
      end
      take_result();
      beat(3, 1, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd3 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL sat_cleared: valid=%b sum=%0d sat=%b, need 1 3 0", out_valid, out_sum, out_sat);
      end
      take_result();
   endtask

   task automatic test_overrun();
      beat(1, 1, 0, 2);
      beat(1, 0, 0, 0);
      beat(1, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_early: valid=%b need 0", out_valid);
      end
      beat(1, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd4 || out_overrun !== 1'b1 || out_fire !== 1'b1) begin
         errors++;
         $display("FAIL overrun: valid=%b sum=%0d ov=%b fire=%b, need 1 4 1 1", out_valid, out_sum, out_overrun, out_fire);
      end
      take_result();
      beat(1, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL orphan_beat: valid=%b need 0", out_valid);
      end
      beat(2, 1, 1, 0);
      checks++;
      if (out_sum !== 8'd2 || out_overrun !== 1'b0) begin
         errors++;
         $display("FAIL after_orphan: sum=%0d ov=%b, need 2 0", out_sum, out_overrun);
      end
      take_result();
   endtask

   task automatic test_restart();
      int pulses;
      beat(20, 1, 0, 100);
      beat(20, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL restart_partial: valid=%b need 0", out_valid);
      end
      beat(7, 1, 1, 7);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd7 || out_fire !== 1'b1) begin
         errors++;
         $display("FAIL restart: valid=%b sum=%0d fire=%b, need 1 7 1", out_valid, out_sum, out_fire);
      end
      take_result();
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL restart_extra: extra result cycles=%0d need 0", pulses);
      end
   endtask

   task automatic test_reset_midway();
      beat(30, 1, 0, 0);
      beat(30, 0, 0, 0);
      pulse_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_acc: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      beat(4, 1, 0, 0);
      beat(5, 0, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd9) begin
         errors++;
         $display("FAIL after_acc_reset: valid=%b sum=%0d, need 1 9", out_valid, out_sum);
      end
      take_result();
      beat(6, 1, 1, 0);
      pulse_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_done: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      beat(8, 1, 1, 9);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd8 || out_fire !== 1'b0) begin
         errors++;
         $display("FAIL after_done_reset: valid=%b sum=%0d fire=%b, need 1 8 0", out_valid, out_sum, out_fire);
      end
      take_result();
   endtask

   initial begin
      test_reset();
      test_three_beats();
      test_backpressure();
      test_saturation();
      test_overrun();
      test_restart();
      test_reset_midway();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
